// File: rtl/if_fetch_queue.sv
// ============================================================================
//  Module   : if_fetch_queue
//  Purpose  : Instruction-fetch front end: drives the fetch PC to the memory
//             controller, tag-matches responses and queues them for decode.
//  Options  : IF_BYPASS_EN - empty-queue responses go straight to decode.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic        pc_done,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_pc_i,
    output logic [31:0] pc_o,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        q_full
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW:0]   count_q,    count_d;

    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];

    logic          head_valid;
    logic          redirect;
    logic          tag_hit;
    logic          pop;
    logic          accept;
    logic          bypass;
    logic          push;

    assign head_valid = (count_q != '0);
    assign redirect   = rdy_in && branch_en;
    assign tag_hit    = pc_done && (inst_pc_i == fetch_pc_q);
    assign pop        = rdy_in && !branch_en && head_valid && id_ready;
    assign accept     = rdy_in && !branch_en && tag_hit
                        && ((count_q < CNT_FULL) || pop);

`ifdef IF_BYPASS_EN
    // An empty queue with decode ready hands the response over directly.
    assign bypass     = accept && !head_valid && id_ready;
`else
    assign bypass     = 1'b0;
`endif

    assign push       = accept && !bypass;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            // Queue is flushed by collapsing the read pointer onto the write pointer.
            fetch_pc_d = branch_target;
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= PC_RESET;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_inst_q[wr_ptr_q] <= inst_i;
        end
    end

    always_comb begin
        if_valid = head_valid;
        if_inst  = head_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
        if_pc    = head_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
        if (bypass) begin
            if_valid = 1'b1;
            if_inst  = inst_i;
            if_pc    = fetch_pc_q;
        end
    end

    assign pc_o   = fetch_pc_q;
    assign q_full = (count_q == CNT_FULL);

endmodule

`default_nettype wire
